mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 122 ++++++++++++
 tb/tb_mdu_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
interface mdu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallE;
    logic            DoneE;
    logic [XLEN-1:0] ResultE;

    modport master (
        output StartE, funct3E, SrcAE, SrcBE, FlushE,
        input  StallE, DoneE, ResultE
    );

    modport slave (
        input  StartE, funct3E, SrcAE, SrcBE, FlushE,
        output StallE, DoneE, ResultE
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-division step per cycle.
// Corner cases (divide by zero, signed overflow, unsupported funct3) complete without iterating.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    mdu_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [5:0] LastStep = 6'(XLEN - 1);

    state_t          state, stateNext;
    logic [5:0]      count;
    logic [XLEN-1:0] opA, opB, acc;
    logic            isMul, isRem, negQ, negR;

    logic            accept, isSigned, isDivOp, unsupported, divZero, overflow, quick;
    logic [XLEN-1:0] quickResult, magA, magB;
    logic [XLEN-1:0] mulAcc, remNext, quoNext, finalResult;
    logic [XLEN:0]   remShift;
    logic            fits;

    always_comb begin
        accept      = (state == IDLE) && bus.StartE && !bus.FlushE;
        isSigned    = (bus.funct3E == 3'b100) || (bus.funct3E == 3'b110);
        isDivOp     = bus.funct3E[2];
        unsupported = !bus.funct3E[2] && (bus.funct3E != 3'b000);
        divZero     = isDivOp && (bus.SrcBE == '0);
        overflow    = isSigned && (bus.SrcAE == MinInt) && (bus.SrcBE == AllOnes);
        quick       = unsupported || divZero || overflow;
        quickResult = '0;
        if (divZero)
            quickResult = bus.funct3E[1] ? bus.SrcAE : AllOnes;
        else if (overflow)
            quickResult = bus.funct3E[1] ? '0 : MinInt;
        magA = (isSigned && bus.SrcAE[XLEN-1]) ? -bus.SrcAE : bus.SrcAE;
        magB = (isSigned && bus.SrcBE[XLEN-1]) ? -bus.SrcBE : bus.SrcBE;
    end

    // opA doubles as the multiplicand and the dividend/quotient shift register; acc holds product or remainder.
    always_comb begin
        mulAcc   = acc + (opB[0] ? opA : '0);
        remShift = {acc, opA[XLEN-1]};
        fits     = (remShift >= {1'b0, opB});
        remNext  = fits ? (remShift[XLEN-1:0] - opB) : remShift[XLEN-1:0];
        quoNext  = {opA[XLEN-2:0], fits};
        if (isMul)
            finalResult = mulAcc;
        else if (isRem)
            finalResult = negR ? -remNext : remNext;
        else
            finalResult = negQ ? -quoNext : quoNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = quick ? DONE : CALC;
            CALC: begin
                if (bus.FlushE)
                    stateNext = IDLE;
                else if (count == LastStep)
                    stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            opA         <= '0;
            opB         <= '0;
            acc         <= '0;
            isMul       <= 1'b0;
            isRem       <= 1'b0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            bus.ResultE <= '0;
        end else if (accept) begin
            count <= '0;
            acc   <= '0;
            isMul <= (bus.funct3E == 3'b000);
            isRem <= bus.funct3E[1];
            negQ  <= isSigned && (bus.SrcAE[XLEN-1] ^ bus.SrcBE[XLEN-1]);
            negR  <= isSigned && bus.SrcAE[XLEN-1];
            opA   <= (bus.funct3E == 3'b000) ? bus.SrcAE : magA;
            opB   <= (bus.funct3E == 3'b000) ? bus.SrcBE : magB;
            if (quick)
                bus.ResultE <= quickResult;
        end else if (state == CALC && !bus.FlushE) begin
            if (count != 6'(XLEN))
                count <= count + 6'd1;
            if (isMul) begin
                acc <= mulAcc;
                opA <= opA << 1;
                opB <= opB >> 1;
            end else begin
                acc <= remNext;
                opA <= quoNext;
            end
            if (count == LastStep)
                bus.ResultE <= finalResult;
        end
    end

    // Stall is withheld during reset so a held StartE cannot freeze the pipeline.
    assign bus.StallE = !rst && ((state == CALC) || accept);
    assign bus.DoneE  = (state == DONE);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: timing, arithmetic, corner cases, flush and reset.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mdu_ctrl_if #(.XLEN(32)) bus();
    mdu_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Launches one op in the current cycle (cycle 0) and watches until DoneE or a 60-cycle limit.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output int doneCycle, output logic [31:0] res, output logic stall0,
                                 output int stallGaps, output logic stallAtDone, output logic doneAfter);
        bus.StartE = 1'b1;
        bus.funct3E = f3;
        bus.SrcAE = a;
        bus.SrcBE = b;
        #1;
        stall0 = bus.StallE;
        doneCycle = -1;
        stallGaps = 0;
        res = '0;
        stallAtDone = 1'b1;
        doneAfter = 1'b1;
        for (int cyc = 1; cyc <= 60 && doneCycle < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                bus.StartE = 1'b0;
                bus.SrcAE = ~a;
                bus.SrcBE = ~b;
            end
            #1;
            if (bus.DoneE === 1'b1) begin
                doneCycle = cyc;
                res = bus.ResultE;
                stallAtDone = bus.StallE;
            end else if (bus.StallE !== 1'b1) begin
                stallGaps++;
            end
        end
        if (doneCycle >= 0) begin
            @(posedge clk);
            #2;
            doneAfter = bus.DoneE;
        end
    endtask

    task automatic test_reset();
        bus.StartE = 1'b1;
        bus.funct3E = 3'b001;
        bus.SrcAE = 32'h0;
        bus.SrcBE = 32'h0;
        bus.FlushE = 1'b0;
        #2;
        checks++; if (bus.StallE !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall actual=%b required=0", bus.StallE); end
        checks++; if (bus.DoneE !== 1'b0) begin fails++; $display("[TB] FAIL reset_done actual=%b required=0", bus.DoneE); end
        checks++; if (bus.ResultE !== 32'h0) begin fails++; $display("[TB] FAIL reset_result actual=%h required=0", bus.ResultE); end
        @(posedge clk);
        #2;
        checks++; if (bus.DoneE !== 1'b0) begin fails++; $display("[TB] FAIL reset_done_edge actual=%b required=0", bus.DoneE); end
        bus.StartE = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int dc, gaps;
        logic [31:0] r;
        logic s0, sd, da;
        applyStimulus(3'b000, 32'd7, 32'd6, dc, r, s0, gaps, sd, da);
        checks++; if (s0 !== 1'b1) begin fails++; $display("[TB] FAIL mul_stall_c0 actual=%b required=1", s0); end
        checks++; if (gaps !== 0) begin fails++; $display("[TB] FAIL mul_stall_calc gaps=%0d required=0", gaps); end
        checks++; if (dc !== 33) begin fails++; $display("[TB] FAIL mul_done_cycle actual=%0d required=33", dc); end
        checks++; if (r !== 32'h2A) begin fails++; $display("[TB] FAIL mul_7x6 actual=%h required=0000002a", r); end
        checks++; if (sd !== 1'b0) begin fails++; $display("[TB] FAIL mul_stall_done actual=%b required=0", sd); end
        checks++; if (da !== 1'b0) begin fails++; $display("[TB] FAIL mul_done_pulse actual=%b required=0", da); end
        applyStimulus(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, r, s0, gaps, sd, da);
        checks++; if (r !== 32'h1) begin fails++; $display("[TB] FAIL mul_neg1sq actual=%h required=00000001", r); end
        applyStimulus(3'b000, 32'h12345678, 32'd9, dc, r, s0, gaps, sd, da);
        checks++; if (r !== 32'hA3D70A38) begin fails++; $display("[TB] FAIL mul_x9 actual=%h required=a3d70a38", r); end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
        logic [31:0] va [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF};
        logic [31:0] vb [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
        logic [31:0] ex [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
        int dc, gaps;
        logic [31:0] r;
        logic s0, sd, da;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(f3[i], va[i], vb[i], dc, r, s0, gaps, sd, da);
            checks++; if (r !== ex[i]) begin fails++; $display("[TB] FAIL div_vec%0d actual=%h required=%h", i, r, ex[i]); end
            checks++; if (dc !== 33) begin fails++; $display("[TB] FAIL div_vec%0d_cycle actual=%0d required=33", i, dc); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b001, 3'b011};
        logic [31:0] va [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'd9};
        logic [31:0] vb [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3};
        logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'd0};
        int dc, gaps;
        logic [31:0] r;
        logic s0, sd, da;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(f3[i], va[i], vb[i], dc, r, s0, gaps, sd, da);
            checks++; if (r !== ex[i]) begin fails++; $display("[TB] FAIL special_vec%0d actual=%h required=%h", i, r, ex[i]); end
            checks++; if (dc !== 1) begin fails++; $display("[TB] FAIL special_vec%0d_cycle actual=%0d required=1", i, dc); end
        end
        applyStimulus(3'b101, 32'h80000000, 32'hFFFFFFFF, dc, r, s0, gaps, sd, da);
        checks++; if (r !== 32'd0 || dc !== 33) begin fails++; $display("[TB] FAIL divu_not_overflow actual=%h/%0d required=0/33", r, dc); end
    endtask

    task automatic test_flush();
        int dc, gaps, pulses;
        logic [31:0] r;
        logic s0, sd, da;
        applyStimulus(3'b000, 32'd3, 32'd5, dc, r, s0, gaps, sd, da);
        checks++; if (r !== 32'd15) begin fails++; $display("[TB] FAIL flush_prior actual=%h required=0000000f", r); end
        bus.StartE = 1'b1;
        bus.funct3E = 3'b100;
        bus.SrcAE = 32'd100;
        bus.SrcBE = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            #2;
            if (cyc == 1) bus.StartE = 1'b0;
            if (cyc == 10) bus.FlushE = 1'b1;
        end
        @(posedge clk);
        #2;
        bus.FlushE = 1'b0;
        #1;
        checks++; if (bus.StallE !== 1'b0) begin fails++; $display("[TB] FAIL flush_stall_c11 actual=%b required=0", bus.StallE); end
        pulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.DoneE === 1'b1) pulses++;
            @(posedge clk);
            #2;
        end
        checks++; if (pulses !== 0) begin fails++; $display("[TB] FAIL flush_no_done pulses=%0d required=0", pulses); end
        checks++; if (bus.ResultE !== 32'd15) begin fails++; $display("[TB] FAIL flush_result_kept actual=%h required=0000000f", bus.ResultE); end
        bus.StartE = 1'b1;
        bus.funct3E = 3'b001;
        bus.FlushE = 1'b1;
        #1;
        checks++; if (bus.StallE !== 1'b0) begin fails++; $display("[TB] FAIL flush_idle_stall actual=%b required=0", bus.StallE); end
        @(posedge clk);
        #2;
        checks++; if (bus.DoneE !== 1'b0) begin fails++; $display("[TB] FAIL flush_idle_blocks actual=%b required=0", bus.DoneE); end
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(3'b000, 32'd3, 32'd3, dc, r, s0, gaps, sd, da);
        checks++; if (r !== 32'd9 || dc !== 33) begin fails++; $display("[TB] FAIL flush_then_mul actual=%h/%0d required=9/33", r, dc); end
    endtask

    task automatic test_reset_mid();
        int dc, gaps;
        logic [31:0] r;
        logic s0, sd, da;
        bus.StartE = 1'b1;
        bus.funct3E = 3'b000;
        bus.SrcAE = 32'd7;
        bus.SrcBE = 32'd6;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.StallE !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_stall actual=%b required=0", bus.StallE); end
        checks++; if (bus.ResultE !== 32'd0) begin fails++; $display("[TB] FAIL rstmid_result actual=%h required=0", bus.ResultE); end
        checks++; if (bus.DoneE !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_done actual=%b required=0", bus.DoneE); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(3'b000, 32'd7, 32'd6, dc, r, s0, gaps, sd, da);
        checks++; if (dc !== 33) begin fails++; $display("[TB] FAIL rstmid_restart_cycle actual=%0d required=33", dc); end
        checks++; if (r !== 32'h2A) begin fails++; $display("[TB] FAIL rstmid_restart_result actual=%h required=0000002a", r); end
    endtask

    task automatic test_back_to_back();
        int n, d0, d1;
        logic [31:0] r0, r1;
        logic stall34;
        n = 0; d0 = -1; d1 = -1; r0 = '0; r1 = '0; stall34 = 1'b0;
        bus.StartE = 1'b1;
        bus.funct3E = 3'b000;
        bus.SrcAE = 32'd5;
        bus.SrcBE = 32'd5;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk);
            #2;
            if (cyc == 34) stall34 = bus.StallE;
            if (cyc == 35) bus.StartE = 1'b0;
            if (bus.DoneE === 1'b1) begin
                n++;
                if (n == 1) begin
                    d0 = cyc; r0 = bus.ResultE;
                    bus.funct3E = 3'b101;
                    bus.SrcAE = 32'd100;
                    bus.SrcBE = 32'd7;
                end else if (n == 2) begin
                    d1 = cyc; r1 = bus.ResultE;
                end
            end
        end
        checks++; if (n !== 2) begin fails++; $display("[TB] FAIL b2b_done_count actual=%0d required=2", n); end
        checks++; if (d0 !== 33 || r0 !== 32'd25) begin fails++; $display("[TB] FAIL b2b_first actual=%h@%0d required=19@33", r0, d0); end
        checks++; if (stall34 !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept_stall actual=%b required=1", stall34); end
        checks++; if (d1 !== 67 || r1 !== 32'd14) begin fails++; $display("[TB] FAIL b2b_second actual=%h@%0d required=0e@67", r1, d1); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
